// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch aligner: FSM states, redirect sources
// and the byte-pointer width derived from the IBuf geometry.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fa_state_e;

    typedef enum logic [1:0] {
        CF_NONE    = 2'd0,
        CF_INIT    = 2'd1,
        CF_RESTEER = 2'd2,
        CF_BRANCH  = 2'd3
    } cf_src_e;

    function automatic int bip_width(input int num_lines, input int line_bytes);
        return $clog2(num_lines * line_bytes);
    endfunction

endpackage

// File: rtl/byte_rotator.sv
// Logarithmic byte barrel rotator: rotates the input right by `shift` bytes so
// byte `shift` lands in the LSB byte, then keeps the low OUT_BYTES bytes.
module byte_rotator #(
    parameter int  N_BYTES   = 64,
    parameter int  OUT_BYTES = 16,
    localparam int SH_W      = $clog2(N_BYTES)
) (
    input  logic [N_BYTES*8-1:0]   data,
    input  logic [SH_W-1:0]        shift,
    output logic [OUT_BYTES*8-1:0] rotated
);
    localparam int W = N_BYTES * 8;

    logic [W-1:0] rot_s;

    // Stage k rotates right by 2**k bytes when shift bit k is set.
    always_comb begin
        rot_s = data;
        for (int k = 0; k < SH_W; k++) begin
            if (shift[k]) begin
                rot_s = (rot_s >> (8 << k)) | (rot_s << (W - (8 << k)));
            end else begin
                rot_s = rot_s;
            end
        end
        rotated = rot_s[OUT_BYTES*8-1:0];
    end

endmodule

// File: rtl/fetch_align_q.sv
// Fetch aligner: extracts PKT_BYTES-byte packets from a circular IBuf at the
// current byte pointer, handles redirects, flush hold and packet injection.
module fetch_align_q
    import fetch_pkg::*;
#(
    parameter int  NUM_LINES  = 4,
    parameter int  LINE_BYTES = 16,
    parameter int  PKT_BYTES  = 16,
    parameter int  LEN_W      = 8,
    localparam int BIP_W      = bip_width(NUM_LINES, LINE_BYTES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_LINES*LINE_BYTES*8-1:0] line_data,
    input  logic [NUM_LINES-1:0]              line_valid,
    output logic [NUM_LINES-1:0]              line_release,
    input  logic                              cf_init,
    input  logic [BIP_W-1:0]                  init_BIP,
    input  logic                              resteer,
    input  logic [BIP_W-1:0]                  WB_BIP,
    input  logic                              br_taken,
    input  logic [BIP_W-1:0]                  BP_BIP,
    input  logic                              flush,
    input  logic                              alt_select,
    input  logic [PKT_BYTES*8-1:0]            alt_packet,
    input  logic                              ie_hold,
    input  logic [LEN_W-1:0]                  D_length,
    output logic [PKT_BYTES*8-1:0]            pkt_out,
    output logic                              pkt_valid,
    input  logic                              pkt_ready,
    output logic [BIP_W-1:0]                  pkt_BIP
);
    localparam int TOT_BYTES = NUM_LINES * LINE_BYTES;
    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int LIDX_W    = $clog2(NUM_LINES);

    fa_state_e              state_r, state_nxt_s;
    cf_src_e                cf_src_s;
    logic                   run_s, cf_s;
    logic [BIP_W-1:0]       cf_target_s, bip_r, bip_nxt_s, pkt_bip_r, pkt_bip_nxt_s;
    logic [BIP_W-1:0]       len_s, adv_s, next_start_s;
    logic [PKT_BYTES*8-1:0] pkt_out_r, pkt_out_nxt_s, rot_s;
    logic                   pkt_valid_r, valid_nxt_s, alt_r, alt_nxt_s;
    logic                   accept_s, fetch_acc_s, empty_or_acc_s;
    logic                   need_next_s, win_ok_s, fetch_load_s, alt_load_s;
    logic [NUM_LINES-1:0]   release_r, release_nxt_s;
    logic [LIDX_W-1:0]      start_line_s, next_line_s, old_line_s;
    logic [OFF_W-1:0]       start_off_s;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: init always wins and lands in RUN even with flush high.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = cf_init ? ST_RUN : ST_IDLE;
            ST_RUN:  begin
                if (cf_init)    state_nxt_s = ST_RUN;
                else if (flush) state_nxt_s = ST_HOLD;
                else            state_nxt_s = ST_RUN;
            end
            ST_HOLD: begin
                if (cf_init || !flush) state_nxt_s = ST_RUN;
                else                   state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: redirect arbitration (init > resteer > branch).
    always_comb begin
        run_s       = 1'b0;
        cf_src_s    = CF_NONE;
        cf_target_s = bip_r;
        case (state_r)
            ST_RUN:  run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
        if (cf_init) begin
            cf_src_s    = CF_INIT;
            cf_target_s = init_BIP;
        end else if (resteer && !flush) begin
            cf_src_s    = CF_RESTEER;
            cf_target_s = WB_BIP;
        end else if (br_taken && run_s) begin
            cf_src_s    = CF_BRANCH;
            cf_target_s = BP_BIP;
        end else begin
            cf_src_s    = CF_NONE;
            cf_target_s = bip_r;
        end
        cf_s = (cf_src_s != CF_NONE);
    end

    // Next packet start and completeness of the IBuf window behind it.
    always_comb begin
        len_s          = BIP_W'(D_length);
        accept_s       = pkt_valid_r & pkt_ready;
        fetch_acc_s    = accept_s & ~alt_r;
        empty_or_acc_s = ~pkt_valid_r | accept_s;
        adv_s          = pkt_bip_r + len_s;
        if (fetch_acc_s) begin
            next_start_s = adv_s;
        end else begin
            next_start_s = bip_r;
        end
        old_line_s   = pkt_bip_r[BIP_W-1 -: LIDX_W];
        start_line_s = next_start_s[BIP_W-1 -: LIDX_W];
        start_off_s  = next_start_s[OFF_W-1:0];
        next_line_s  = start_line_s + LIDX_W'(1'b1);
        need_next_s  = (int'(start_off_s) + PKT_BYTES) > LINE_BYTES;
        win_ok_s     = line_valid[start_line_s] & (~need_next_s | line_valid[next_line_s]);
    end

    byte_rotator #(
        .N_BYTES   (TOT_BYTES),
        .OUT_BYTES (PKT_BYTES)
    ) u_rot (
        .data    (line_data),
        .shift   (next_start_s),
        .rotated (rot_s)
    );

    // Output-register next values; an injected packet never moves the pointers.
    always_comb begin
        alt_load_s    = run_s & alt_select & ~flush & empty_or_acc_s & ~cf_s;
        fetch_load_s  = run_s & ~alt_select & ~flush & empty_or_acc_s & ~cf_s
                        & ~ie_hold & win_ok_s;
        bip_nxt_s     = bip_r;
        pkt_bip_nxt_s = pkt_bip_r;
        pkt_out_nxt_s = pkt_out_r;
        valid_nxt_s   = pkt_valid_r;
        alt_nxt_s     = alt_r;
        release_nxt_s = {NUM_LINES{1'b0}};
        if (cf_s) begin
            bip_nxt_s     = cf_target_s;
            valid_nxt_s   = 1'b0;
            alt_nxt_s     = 1'b0;
            release_nxt_s = {NUM_LINES{1'b1}};
        end else begin
            if (fetch_acc_s) begin
                bip_nxt_s = adv_s;
                if (start_line_s != old_line_s) begin
                    release_nxt_s[old_line_s] = 1'b1;
                end else begin
                    release_nxt_s = {NUM_LINES{1'b0}};
                end
            end else begin
                bip_nxt_s = bip_r;
            end
            if (fetch_load_s) begin
                pkt_bip_nxt_s = next_start_s;
                pkt_out_nxt_s = rot_s;
                valid_nxt_s   = 1'b1;
                alt_nxt_s     = 1'b0;
            end else if (alt_load_s) begin
                pkt_out_nxt_s = alt_packet;
                valid_nxt_s   = 1'b1;
                alt_nxt_s     = 1'b1;
            end else if (accept_s || flush || !run_s) begin
                valid_nxt_s = 1'b0;
                alt_nxt_s   = 1'b0;
            end else begin
                valid_nxt_s = pkt_valid_r;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bip_r       <= {BIP_W{1'b0}};
            pkt_bip_r   <= {BIP_W{1'b0}};
            pkt_out_r   <= {(PKT_BYTES*8){1'b0}};
            pkt_valid_r <= 1'b0;
            alt_r       <= 1'b0;
            release_r   <= {NUM_LINES{1'b0}};
        end else begin
            bip_r       <= bip_nxt_s;
            pkt_bip_r   <= pkt_bip_nxt_s;
            pkt_out_r   <= pkt_out_nxt_s;
            pkt_valid_r <= valid_nxt_s;
            alt_r       <= alt_nxt_s;
            release_r   <= release_nxt_s;
        end
    end

    assign pkt_out      = pkt_out_r;
    assign pkt_valid    = pkt_valid_r;
    assign pkt_BIP      = pkt_bip_r;
    assign line_release = release_r;

endmodule

// File: tb/tb_fetch_align_q.sv
// Directed bench for fetch_align_q: stimulus queues expected packets, a
// monitor pops and compares them on every handshake.
module tb_fetch_align_q;

    logic         clk;
    logic         reset;
    logic [511:0] line_data;
    logic [3:0]   line_valid;
    logic [3:0]   line_release;
    logic         cf_init, resteer, br_taken, flush, alt_select, ie_hold, pkt_ready;
    logic [5:0]   init_BIP, WB_BIP, BP_BIP;
    logic [127:0] alt_packet;
    logic [7:0]   D_length;
    logic [127:0] pkt_out;
    logic         pkt_valid;
    logic [5:0]   pkt_BIP;

    typedef struct packed {
        logic [127:0] pkt;
        logic [5:0]   bip;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_align_q dut (
        .clk          (clk),
        .reset        (reset),
        .line_data    (line_data),
        .line_valid   (line_valid),
        .line_release (line_release),
        .cf_init      (cf_init),
        .init_BIP     (init_BIP),
        .resteer      (resteer),
        .WB_BIP       (WB_BIP),
        .br_taken     (br_taken),
        .BP_BIP       (BP_BIP),
        .flush        (flush),
        .alt_select   (alt_select),
        .alt_packet   (alt_packet),
        .ie_hold      (ie_hold),
        .D_length     (D_length),
        .pkt_out      (pkt_out),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_BIP      (pkt_BIP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line k byte j holds 0xkj, so the byte at buffer offset a is simply a.
    function automatic logic [127:0] fpkt(input logic [5:0] s);
        logic [5:0] a;
        fpkt = 128'd0;
        for (int i = 0; i < 16; i++) begin
            a = s + 6'(i);
            fpkt[i*8 +: 8] = {2'b00, a};
        end
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h need %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic side(input string tag, input logic v, input logic [3:0] rel);
        @(negedge clk);
        chk({tag, "_valid"}, pkt_valid, v);
        chk({tag, "_release"}, line_release, rel);
    endtask

    task automatic offer(input logic [5:0] b, input logic [7:0] d);
        exp_t e;
        pkt_ready = 1'b1;
        D_length  = d;
        e.pkt     = fpkt(b);
        e.bip     = b;
        exp_q.push_back(e);
    endtask

    task automatic offer_alt(input logic [7:0] d);
        exp_t e;
        pkt_ready = 1'b1;
        D_length  = d;
        e.pkt     = {16{8'hA5}};
        e.bip     = 6'h00;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && pkt_valid && pkt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got bip %0h with nothing expected", pkt_BIP);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pkt_out !== e.pkt || pkt_BIP !== e.bip) begin
                    errors++;
                    $display("FAIL sb_pkt: got bip %0h out %0h need bip %0h out %0h",
                             pkt_BIP, pkt_out, e.bip, e.pkt);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; cf_init = 1'b0; init_BIP = 6'h00; resteer = 1'b0; WB_BIP = 6'h00;
        br_taken = 1'b0; BP_BIP = 6'h00; flush = 1'b0; alt_select = 1'b0;
        alt_packet = {16{8'hA5}}; ie_hold = 1'b0; D_length = 8'd0; pkt_ready = 1'b0;
        line_valid = 4'hF;
        for (int a = 0; a < 64; a++) line_data[a*8 +: 8] = 8'(a);
        tick(); tick();
        @(negedge clk);
        chk("rst_valid", pkt_valid, 1'b0);
        chk("rst_bip", pkt_BIP, 6'h00);
        chk("rst_out", pkt_out, 128'd0);
        chk("rst_release", line_release, 4'h0);

        tick(); reset = 1'b1; cf_init = 1'b1; init_BIP = 6'h00;
        tick(); cf_init = 1'b0;            side("init_p1", 1'b0, 4'hF);
        tick(); offer(6'h00, 8'd12);       side("init_p2", 1'b1, 4'h0);
        tick(); offer(6'h0C, 8'd5);        side("s0C", 1'b1, 4'h0);
        tick(); offer(6'h11, 8'd5);        side("s11", 1'b1, 4'b0001);
        tick(); offer(6'h16, 8'd5);        side("s16", 1'b1, 4'h0);
        tick(); pkt_ready = 1'b0;
        @(negedge clk); chk("hold_bip_a", pkt_BIP, 6'h1B);
        tick();
        @(negedge clk); chk("hold_bip_b", pkt_BIP, 6'h1B); chk("hold_out", pkt_out, fpkt(6'h1B));

        tick(); resteer = 1'b1; WB_BIP = 6'h20; br_taken = 1'b1; BP_BIP = 6'h10;
        offer(6'h1B, 8'd5);
        tick(); resteer = 1'b0; br_taken = 1'b0; pkt_ready = 1'b0;
        side("cf_p1", 1'b0, 4'hF);
        tick(); offer(6'h20, 8'h1A); line_valid = 4'b1110; side("rs20", 1'b1, 4'h0);
        tick(); pkt_ready = 1'b0;          side("win_miss_a", 1'b0, 4'b0100);
        tick(); line_valid = 4'hF;         side("win_miss_b", 1'b0, 4'h0);
        tick(); offer(6'h3A, 8'd6);        side("s3A", 1'b1, 4'h0);

        tick(); alt_select = 1'b1; offer(6'h00, 8'd4); side("s00", 1'b1, 4'b1000);
        tick(); offer_alt(8'd9);           side("alt_a", 1'b1, 4'h0);
        tick(); alt_select = 1'b0; offer_alt(8'd9); side("alt_b", 1'b1, 4'h0);
        tick(); ie_hold = 1'b1; offer(6'h04, 8'd2); side("post_alt", 1'b1, 4'h0);
        tick(); pkt_ready = 1'b0;          side("ie_hold_a", 1'b0, 4'h0);
        tick(); ie_hold = 1'b0;            side("ie_hold_b", 1'b0, 4'h0);
        tick();                            side("s06_held", 1'b1, 4'h0);
        chk("s06_bip", pkt_BIP, 6'h06);

        tick(); flush = 1'b1; resteer = 1'b1; WB_BIP = 6'h30;
        tick(); resteer = 1'b0;            side("hold", 1'b0, 4'h0);
        tick(); cf_init = 1'b1; init_BIP = 6'h08;
        tick(); cf_init = 1'b0; flush = 1'b0; side("init08_p1", 1'b0, 4'hF);
        tick(); offer(6'h08, 8'd3);        side("s08", 1'b1, 4'h0);
        tick(); offer(6'h0B, 8'd3);        side("s0B", 1'b1, 4'h0);
        tick(); pkt_ready = 1'b0;
        @(negedge clk); chk("s0E_bip", pkt_BIP, 6'h0E);

        @(posedge clk); #1; reset = 1'b0; #1;
        chk("midrst_valid", pkt_valid, 1'b0);
        chk("midrst_bip", pkt_BIP, 6'h00);
        chk("midrst_out", pkt_out, 128'd0);
        chk("midrst_release", line_release, 4'h0);
        tick(); tick();
        chk("sb_drain", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
